systolic_seq_ctrl: RTL and testbench

Sequencing controller for the 8x8 systolic-array top. It accepts a job over a 16-bit word stream: 64 B words in row-major order, then 8 A words. It drives the array top's write port and shift enables, and streams the 8 bottom partial sums back out. It sits between the host/DMA logic and the array top, and owns every control input of that top.

---
 rtl/systolic_seq_ctrl_if.sv | 20 ++
 rtl/systolic_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_seq_ctrl_if.sv
// Host-side word streams of the systolic sequencing controller:
// job words in (B then A), bottom partial sums out.
interface systolic_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the 8x8 systolic-array top: loads 8 B rows and the A vector,
// runs the array for COMPUTE_CYC cycles, then drains the 8 bottom partial sums.
module systolic_seq_ctrl #(
    parameter int COMPUTE_CYC = 15          // legal range 1..31
) (
    input  logic                       Clock,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    systolic_seq_ctrl_if.slave         host,
    output logic                       busy,
    output logic                       done,
    output logic                       data_clear,
    output logic                       en_b_shift_bottom,
    output logic                       en_shift_right,
    output logic                       en_shift_bottom,
    output logic                       external_we,
    output logic                       sel_a_or_b,
    output logic [7:0]                 b_sel,
    output logic [2:0]                 a_sel,
    output logic [15:0]                external_wdata,
    output logic [2:0]                 ps_sel,
    input  logic [15:0]                ps_bottom_out_selected
);

    localparam logic [4:0] CYC_LAST = 5'(COMPUTE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_B,
        SHIFT_B,
        LOAD_A,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] word_cnt_reg, word_cnt_next;
    logic [2:0] row_cnt_reg, row_cnt_next;
    logic [2:0] drain_cnt_reg, drain_cnt_next;
    logic [4:0] cyc_cnt_reg, cyc_cnt_next;

    always_ff @(posedge Clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            word_cnt_reg  <= '0;
            row_cnt_reg   <= '0;
            drain_cnt_reg <= '0;
            cyc_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            word_cnt_reg  <= word_cnt_next;
            row_cnt_reg   <= row_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            cyc_cnt_reg   <= cyc_cnt_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        word_cnt_next     = word_cnt_reg;
        row_cnt_next      = row_cnt_reg;
        drain_cnt_next    = drain_cnt_reg;
        cyc_cnt_next      = cyc_cnt_reg;
        host.in_ready     = 1'b0;
        host.out_valid    = 1'b0;
        host.out_data     = '0;
        data_clear        = 1'b0;
        en_b_shift_bottom = 1'b0;
        en_shift_right    = 1'b0;
        en_shift_bottom   = 1'b0;
        external_we       = 1'b0;
        external_wdata    = '0;
        sel_a_or_b        = 1'b0;
        done              = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                data_clear    = 1'b1;
                word_cnt_next = '0;
                row_cnt_next  = '0;
                state_next    = LOAD_B;
            end
            LOAD_B, LOAD_A: begin
                // Write strobe follows the handshake directly so a word lands the cycle it is accepted.
                host.in_ready  = 1'b1;
                sel_a_or_b     = (state_reg == LOAD_A);
                external_we    = host.in_valid;
                external_wdata = host.in_data;
                if (host.in_valid) begin
                    if (word_cnt_reg == 3'd7) begin
                        word_cnt_next = '0;
                        if (state_reg == LOAD_A) begin
                            cyc_cnt_next = '0;
                            state_next   = COMPUTE;
                        end else begin
                            state_next   = SHIFT_B;
                        end
                    end else begin
                        word_cnt_next = word_cnt_reg + 3'd1;
                    end
                end
            end
            SHIFT_B: begin
                en_b_shift_bottom = 1'b1;
                if (row_cnt_reg == 3'd7) begin
                    word_cnt_next = '0;
                    state_next    = LOAD_A;
                end else begin
                    row_cnt_next  = row_cnt_reg + 3'd1;
                    state_next    = LOAD_B;
                end
            end
            COMPUTE: begin
                en_shift_right  = 1'b1;
                en_shift_bottom = 1'b1;
                if (cyc_cnt_reg == CYC_LAST) begin
                    drain_cnt_next = '0;
                    state_next     = DRAIN;
                end else begin
                    cyc_cnt_next   = cyc_cnt_reg + 5'd1;
                end
            end
            DRAIN: begin
                // Array is frozen here, so out_data stays stable while the sink stalls.
                host.out_valid = 1'b1;
                host.out_data  = ps_bottom_out_selected;
                if (host.out_ready) begin
                    if (drain_cnt_reg == 3'd7) begin
                        drain_cnt_next = '0;
                        state_next     = DONE;
                    end else begin
                        drain_cnt_next = drain_cnt_reg + 3'd1;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next     = IDLE;
            word_cnt_next  = '0;
            row_cnt_next   = '0;
            drain_cnt_next = '0;
            cyc_cnt_next   = '0;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign b_sel  = {5'b0, word_cnt_reg};
    assign a_sel  = word_cnt_reg;
    assign ps_sel = drain_cnt_reg;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized job bench for systolic_seq_ctrl: two builds (COMPUTE_CYC 15 and 1),
// each driving a small behavioural model of the array top.
module tb_systolic_seq_ctrl;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    logic        rst_n;
    logic        start_drv, abort_drv, in_valid_drv, out_ready_drv;
    logic [15:0] in_data_drv;
    logic        dsel;
    logic [1:0]  start_v;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_seq_ctrl_if if0 ();
    systolic_seq_ctrl_if if1 ();

    assign if0.in_valid  = in_valid_drv;
    assign if0.in_data   = in_data_drv;
    assign if0.out_ready = out_ready_drv;
    assign if1.in_valid  = in_valid_drv;
    assign if1.in_data   = in_data_drv;
    assign if1.out_ready = out_ready_drv;
    assign start_v = dsel ? {start_drv, 1'b0} : {1'b0, start_drv};

    logic [1:0]  busy_v, done_v, clr_v, ebsb_v, esr_v, esb_v, we_v, sel_v;
    logic [7:0]  b_sel_v  [2];
    logic [2:0]  a_sel_v  [2];
    logic [2:0]  ps_sel_v [2];
    logic [15:0] wdata_v  [2];
    logic [15:0] psb_v    [2];

    systolic_seq_ctrl #(.COMPUTE_CYC(15)) dut0 (
        .Clock(Clock), .rst_n(rst_n), .start(start_v[0]), .abort(abort_drv), .host(if0),
        .busy(busy_v[0]), .done(done_v[0]), .data_clear(clr_v[0]),
        .en_b_shift_bottom(ebsb_v[0]), .en_shift_right(esr_v[0]), .en_shift_bottom(esb_v[0]),
        .external_we(we_v[0]), .sel_a_or_b(sel_v[0]), .b_sel(b_sel_v[0]), .a_sel(a_sel_v[0]),
        .external_wdata(wdata_v[0]), .ps_sel(ps_sel_v[0]), .ps_bottom_out_selected(psb_v[0])
    );

    systolic_seq_ctrl #(.COMPUTE_CYC(1)) dut1 (
        .Clock(Clock), .rst_n(rst_n), .start(start_v[1]), .abort(abort_drv), .host(if1),
        .busy(busy_v[1]), .done(done_v[1]), .data_clear(clr_v[1]),
        .en_b_shift_bottom(ebsb_v[1]), .en_shift_right(esr_v[1]), .en_shift_bottom(esb_v[1]),
        .external_we(we_v[1]), .sel_a_or_b(sel_v[1]), .b_sel(b_sel_v[1]), .a_sel(a_sel_v[1]),
        .external_wdata(wdata_v[1]), .ps_sel(ps_sel_v[1]), .ps_bottom_out_selected(psb_v[1])
    );

    // Array-top stand-in: B row buffer, shifted-in B rows, A vector, bottom sums.
    logic [15:0] bbuf_m [2][8];
    logic [15:0] bmat_m [2][8][8];
    logic [15:0] av_m   [2][8];
    logic [15:0] ps_m   [2][8];
    int          nrow_m [2];

    function automatic logic [15:0] mac(input int d, input int j);
        logic [15:0] acc;
        acc = '0;
        for (int r = 0; r < 8; r++) acc = acc + 16'(av_m[d][r] * bmat_m[d][r][j]);
        return acc;
    endfunction

    always @(posedge Clock) begin
        for (int d = 0; d < 2; d++) begin
            if (clr_v[d]) begin
                nrow_m[d] <= 0;
                for (int i = 0; i < 8; i++) begin
                    bbuf_m[d][i] <= '0;
                    av_m[d][i]   <= '0;
                    ps_m[d][i]   <= '0;
                    for (int k = 0; k < 8; k++) bmat_m[d][i][k] <= '0;
                end
            end else begin
                if (we_v[d]) begin
                    if (sel_v[d]) av_m[d][a_sel_v[d]] <= wdata_v[d];
                    else if (b_sel_v[d] < 8'd8) bbuf_m[d][b_sel_v[d][2:0]] <= wdata_v[d];
                end
                if (ebsb_v[d]) begin
                    if (nrow_m[d] < 8)
                        for (int k = 0; k < 8; k++) bmat_m[d][nrow_m[d]][k] <= bbuf_m[d][k];
                    nrow_m[d] <= nrow_m[d] + 1;
                end
                if (esr_v[d] && esb_v[d])
                    for (int j = 0; j < 8; j++) ps_m[d][j] <= mac(d, j);
            end
        end
    end

    assign psb_v[0] = ps_m[0][ps_sel_v[0]];
    assign psb_v[1] = ps_m[1][ps_sel_v[1]];

    // Outputs of whichever build is under test.
    logic        busy, done, data_clear, ebsb, esr, esb, we, sel, in_ready, out_valid;
    logic [7:0]  b_sel;
    logic [2:0]  a_sel, ps_sel;
    logic [15:0] wdata, out_data;
    assign busy       = busy_v[dsel];
    assign done       = done_v[dsel];
    assign data_clear = clr_v[dsel];
    assign ebsb       = ebsb_v[dsel];
    assign esr        = esr_v[dsel];
    assign esb        = esb_v[dsel];
    assign we         = we_v[dsel];
    assign sel        = sel_v[dsel];
    assign b_sel      = b_sel_v[dsel];
    assign a_sel      = a_sel_v[dsel];
    assign ps_sel     = ps_sel_v[dsel];
    assign wdata      = wdata_v[dsel];
    assign in_ready   = dsel ? if1.in_ready  : if0.in_ready;
    assign out_valid  = dsel ? if1.out_valid : if0.out_valid;
    assign out_data   = dsel ? if1.out_data  : if0.out_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, {22'b0, busy, done, data_clear, ebsb, esr, esb, we, sel,
                              in_ready, out_valid}, 32'd0);
        check({tag, "_sel"}, {18'b0, b_sel, a_sel, ps_sel}, 32'd0);
        check({tag, "_data"}, {wdata, out_data}, 32'd0);
    endtask

    task automatic run_job(input int d, input bit ident, input int gap_pct, input bit stall3,
                           input bit abort_mid, input bit start_drain, input bit rst_mid);
        logic [15:0] bw   [64];
        logic [15:0] aw   [8];
        logic [15:0] expv [8];
        logic [15:0] acc;
        logic [15:0] prev_data;
        logic [2:0]  prev_ps;
        int idx, nres, nshift, ncomp, ndone, nclear, stall_cnt, clear_cyc, done_cyc, abort_age, ccyc;
        bit fin, aborted, reset_hit, prev_stall, start_sent;
        idx = 0; nres = 0; nshift = 0; ncomp = 0; ndone = 0; nclear = 0; stall_cnt = 0;
        done_cyc = 0; abort_age = 0;
        fin = 0; aborted = 0; reset_hit = 0; prev_stall = 0; start_sent = 0;
        prev_data = '0; prev_ps = '0;
        ccyc = (d == 0) ? 15 : 1;
        dsel = (d != 0);

        for (int i = 0; i < 64; i++)
            bw[i] = ident ? (((i / 8) == (i % 8)) ? 16'd1 : 16'd0) : 16'($urandom);
        for (int r = 0; r < 8; r++) aw[r] = ident ? 16'(r + 1) : 16'($urandom);
        // Result column j is the dot product of A with column j of the streamed B matrix.
        for (int j = 0; j < 8; j++) begin
            acc = '0;
            for (int r = 0; r < 8; r++) acc = acc + 16'(aw[r] * bw[r * 8 + j]);
            expv[j] = acc;
        end

        @(posedge Clock); #1 start_drv = 1'b1;
        @(posedge Clock); #1 start_drv = 1'b0;
        @(negedge Clock);
        check("clear_pulse", data_clear, 1);
        check("busy_rise", busy, 1);
        check("clear_bsel", b_sel, 0);
        clear_cyc = cyc;

        for (int t = 0; t < 3000 && !fin; t++) begin
            @(posedge Clock); #1;
            in_valid_drv  = !aborted && idx < 72 && ($urandom_range(99) >= gap_pct);
            abort_drv     = abort_mid && !aborted && idx == 28;
            if (abort_drv) begin
                aborted      = 1;
                in_valid_drv = 1'b0;
            end
            in_data_drv   = in_valid_drv ? ((idx < 64) ? bw[idx] : aw[idx - 64]) : 16'($urandom);
            out_ready_drv = !(stall3 && nres == 2 && stall_cnt < 5);
            start_drv     = start_drain && !start_sent && nres == 4;
            if (start_drv) start_sent = 1;

            @(negedge Clock);
            if (aborted) abort_age++;
            if (!in_valid_drv) begin
                check("we_without_valid", we, 0);
            end else if (in_ready) begin
                check("we_on_xfer", we, 1);
                check("wdata", wdata, in_data_drv);
                check("sel_a_or_b", sel, idx >= 64);
                if (idx < 64) check("b_sel", b_sel, idx % 8);
                else          check("a_sel", a_sel, idx - 64);
                idx++;
            end
            if (data_clear) nclear++;
            if (ebsb) nshift++;
            if (esr) ncomp++;
            if (esr || esb) check("en_pair", esb, esr);
            if (!aborted) check("busy_hold", busy, 1);
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
                check("stall_ps", ps_sel, prev_ps);
            end
            prev_stall = out_valid && !out_ready_drv;
            prev_data  = out_data;
            prev_ps    = ps_sel;
            if (prev_stall) stall_cnt++;
            if (out_valid && out_ready_drv) begin
                check("ps_sel", ps_sel, nres);
                if (nres < 8) begin
                    check("result", out_data, expv[nres]);
                    $display("RESULT build=%0d col=%0d data=%h expected=%h", d, nres, out_data, expv[nres]);
                end
                nres++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
                fin      = 1;
            end
            if (aborted && abort_age == 2) begin
                check("abort_idle", busy, 0);
                check("abort_in_ready", in_ready, 0);
            end
            if (aborted && abort_age >= 12) fin = 1;
            if (rst_mid && esr && ncomp == 3) begin
                rst_n = 1'b0;
                #1 check_zero_outputs("midjob_reset");
                reset_hit = 1;
                fin       = 1;
            end
        end

        abort_drv     = 1'b0;
        start_drv     = 1'b0;
        in_valid_drv  = 1'b0;
        out_ready_drv = 1'b1;
        if (!fin) begin
            check("timeout", 0, 1);
        end else if (reset_hit) begin
            repeat (2) @(posedge Clock);
            @(negedge Clock);
            check_zero_outputs("reset_held");
            rst_n = 1'b1;
        end else if (aborted) begin
            check("abort_no_done", ndone, 0);
        end else begin
            check("n_results", nres, 8);
            check("n_done", ndone, 1);
            check("n_bshift", nshift, 8);
            check("n_compute", ncomp, ccyc);
            check("n_words", idx, 72);
            check("extra_clear", nclear, 0);
            if (gap_pct == 0 && !stall3)
                check("done_latency", done_cyc - clear_cyc + 1, 90 + ccyc);
            @(negedge Clock);
            check("busy_fall", busy, 0);
            check("done_width", done, 0);
        end
        $display("JOB build=%0d ident=%0d gaps=%0d stall=%0d abort=%0d reset=%0d results=%0d",
                 d, ident, gap_pct, stall3, aborted, reset_hit, nres);
    endtask

    initial begin
        rst_n         = 1'b0;
        start_drv     = 1'b0;
        abort_drv     = 1'b0;
        in_valid_drv  = 1'b0;
        in_data_drv   = '0;
        out_ready_drv = 1'b1;
        dsel          = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check_zero_outputs("reset_build0");
        dsel = 1'b1;
        #1 check_zero_outputs("reset_build1");
        dsel = 1'b0;
        #1 rst_n = 1'b1;

        run_job(0, 1, 0,  0, 0, 0, 0);   // identity, free-flowing
        run_job(0, 1, 30, 1, 0, 0, 0);   // identity under backpressure
        run_job(0, 0, 0,  0, 0, 0, 0);
        run_job(0, 0, 0,  0, 1, 0, 0);   // abort in LOAD_B row 3 word 4
        run_job(0, 0, 20, 0, 0, 0, 0);
        run_job(0, 0, 0,  0, 0, 1, 0);   // start pulse while draining
        run_job(0, 0, 0,  0, 0, 0, 1);   // reset mid-COMPUTE
        run_job(0, 1, 0,  0, 0, 0, 0);
        run_job(1, 1, 0,  0, 0, 0, 0);   // COMPUTE_CYC = 1 build
        run_job(1, 0, 30, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
